// File: rtl/rf_dbg_pkg.sv
// Shared types and defaults for the register-file debug/loader port.
// Values match the 5-stage core's register file.
package rf_dbg_pkg;

  localparam int NREG = 32;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    LOAD,
    DUMP,
    DONE
  } state_e;

endpackage

// File: rtl/regfile_dbg_port.sv
// Host debug port: halts the core, then bulk-loads x1..x31
// or streams x0..x31 out over valid/ready handshakes.
module regfile_dbg_port
  import rf_dbg_pkg::*;
#(
  parameter int NREG = rf_dbg_pkg::NREG,
  parameter int XLEN = rf_dbg_pkg::XLEN,
  parameter int AW   = rf_dbg_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr_d,
  output logic [XLEN-1:0] rf_data_d,
  output logic [AW-1:0]   rf_addr_r,
  input  logic [XLEN-1:0] rf_data_r,
  output logic            busy,
  output logic            done
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_e          state_q, state_d;
  logic            op_q, op_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            halt_q, halt_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            issued_q, issued_d;
  logic            out_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      idx_q       <= '0;
      halt_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      halt_q      <= halt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      issued_q    <= issued_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    halt_d      = halt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    issued_d    = issued_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    rf_we       = 1'b0;
    rf_addr_d   = '0;
    rf_data_d   = '0;
    rf_addr_r   = '0;
    done        = 1'b0;
    out_fire    = out_valid_q & out_ready;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d     = cmd_op;
          idx_d    = (cmd_op == OP_DUMP) ? '0 : AW'(1);
          halt_d   = 1'b1;
          issued_d = 1'b0;
          state_d  = HALT;
        end
      end
      HALT: begin
        if (halt_ack) begin
          if (op_q == OP_DUMP) begin
            // Read port already sits at x0, so the first word is
            // captured here to give out_valid the cycle after ack.
            out_data_d  = rf_data_r;
            out_valid_d = 1'b1;
            idx_d       = idx_q + AW'(1);
            state_d     = DUMP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        rf_we     = in_valid;
        rf_addr_d = idx_q;
        rf_data_d = in_data;
        if (in_valid) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      DUMP: begin
        rf_addr_r = idx_q;
        if (!out_valid_q || out_fire) begin
          if (issued_q) begin
            // Only the x31 word can be in flight once issued is set.
            if (out_fire) begin
              out_valid_d = 1'b0;
              state_d     = DONE;
            end
          end else begin
            out_data_d  = rf_data_r;
            out_valid_d = 1'b1;
            if (idx_q == LAST) begin
              issued_d = 1'b1;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        halt_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign halt_req  = halt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Bench for regfile_dbg_port: model register file plus
// scoreboards for the load write stream and the dump stream.
module tb_regfile_dbg_port;
  import rf_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        halt_req, halt_ack;
  logic        rf_we;
  logic [4:0]  rf_addr_d, rf_addr_r;
  logic [31:0] rf_data_d, rf_data_r;
  logic        busy, done;

  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  regfile_dbg_port dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
    .rf_addr_r(rf_addr_r), .rf_data_r(rf_data_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign rf_data_r = rf[rf_addr_r];

  always @(posedge clk) begin
    if (rf_we === 1'b1) rf[rf_addr_d] <= rf_data_d;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0;
    in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; halt_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, in_ready, out_valid, halt_req, rf_we, busy, done}
        !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000000",
        {cmd_ready, in_ready, out_valid, halt_req, rf_we, busy, done});
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic op);
    cmd_valid = 1'b1; cmd_op = op;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cmd_accept got=%b%b exp=10", cmd_ready, busy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++;
    if ({halt_req, busy, cmd_ready} !== 3'b110) begin
      failures++;
      $display("FAIL cmd_halt got=%b exp=110", {halt_req, busy, cmd_ready});
    end
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, rf_we} !== 3'b000) begin
      failures++;
      $display("FAIL halt_wait got=%b exp=000", {in_ready, out_valid, rf_we});
    end
    @(negedge clk);
    halt_ack = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dump(input bit bp, input bit poke);
    logic [31:0] exp_q[$];
    logic [31:0] held;
    bit stalled;
    int got, cyc, d0;
    d0 = done_cnt;
    for (int k = 0; k < 32; k++) exp_q.push_back(exp_rf[k]);
    send_cmd(1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL dump_first_valid got=%b exp=1", out_valid);
    end
    got = 0; cyc = 0; stalled = 0; held = '0;
    while (got < 32 && cyc < 400) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_valid = poke && (cyc % 5 == 2);
      cmd_op = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL dump_busy got=%b%b exp=01", cmd_ready, busy);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          failures++;
          $display("FAIL dump_stall got=%b/%h exp=1/%h",
            out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_data !== exp_q[0]) begin
          failures++;
          $display("FAIL dump_word%0d got=%h exp=%h",
            got, out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got++;
        stalled = 0;
      end else begin
        stalled = (out_valid === 1'b1);
        held = out_data;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 32 || (!bp && cyc != 32)) begin
      failures++;
      $display("FAIL dump_count got=%0d/%0d exp=32", got, cyc);
    end
    #1;
    checks++;
    if ({done, out_valid, halt_req} !== 3'b101) begin
      failures++;
      $display("FAIL dump_done got=%b exp=101", {done, out_valid, halt_req});
    end
    @(negedge clk);
    halt_ack = 1'b0;
    checks++;
    if ({done, halt_req, busy, cmd_ready} !== 4'b0001
        || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL dump_end got=%b/%0d exp=0001/1",
        {done, halt_req, busy, cmd_ready}, done_cnt - d0);
    end
  endtask

  task automatic test_load(input bit gap, input logic [31:0] base,
                           input int stop_after);
    logic [36:0] exp_q[$];
    int i, cyc, we_cnt, bad, d0;
    d0 = done_cnt;
    send_cmd(1'b0);
    i = 1; cyc = 0; we_cnt = 0;
    while (i <= stop_after && cyc < 200) begin
      in_valid = !(gap && (cyc % 3 == 2));
      in_data = base + 32'(i);
      #1;
      if (in_valid) begin
        exp_q.push_back({5'(i), in_data});
        exp_rf[i] = in_data;
        i++;
      end
      checks++;
      if (in_ready !== 1'b1 || rf_we !== in_valid) begin
        failures++;
        $display("FAIL load_we got=%b%b exp=1%b", in_ready, rf_we, in_valid);
      end
      if (rf_we === 1'b1) begin
        we_cnt++;
        checks++;
        if (exp_q.size() == 0 || {rf_addr_d, rf_data_d} !== exp_q[0]
            || rf_addr_d == 5'd0) begin
          failures++;
          $display("FAIL load_write got=%0d/%h exp=%0d/%h",
            rf_addr_d, rf_data_d, i - 1, base + 32'(i - 1));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (we_cnt != stop_after || (!gap && cyc != stop_after)) begin
      failures++;
      $display("FAIL load_count got=%0d/%0d exp=%0d", we_cnt, cyc, stop_after);
    end
    if (stop_after == 31) begin
      #1;
      checks++;
      if ({done, rf_we, halt_req} !== 3'b101) begin
        failures++;
        $display("FAIL load_done got=%b exp=101", {done, rf_we, halt_req});
      end
      @(negedge clk);
      halt_ack = 1'b0;
      checks++;
      if ({done, halt_req, busy, cmd_ready} !== 4'b0001
          || done_cnt - d0 != 1) begin
        failures++;
        $display("FAIL load_end got=%b/%0d exp=0001/1",
          {done, halt_req, busy, cmd_ready}, done_cnt - d0);
      end
    end else begin
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, halt_req, rf_we, in_ready, cmd_ready} !== 5'b00001) begin
        failures++;
        $display("FAIL midreset got=%b exp=00001",
          {busy, halt_req, rf_we, in_ready, cmd_ready});
      end
      rst = 1'b0;
      halt_ack = 1'b0;
      @(negedge clk);
    end
    bad = 0;
    for (int k = 0; k < 32; k++) if (rf[k] !== exp_rf[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL load_rf got=%0d_bad_regs exp=0", bad);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      rf[k]     = (k == 0) ? 32'h0 : 32'hA500_0000 + 32'(k);
      exp_rf[k] = rf[k];
    end
    test_reset();
    test_dump(1'b0, 1'b0);
    test_dump(1'b1, 1'b1);
    test_load(1'b0, 32'h1000, 31);
    test_load(1'b1, 32'h3000, 31);
    test_load(1'b0, 32'h2000, 10);
    test_dump(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
